// File: rtl/float_multiplier_pipe_if.sv
// Operand/product bus for float_multiplier_pipe: valid-qualified, no backpressure.
interface float_multiplier_pipe_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
);
    localparam int W = 1 + EXP_W + FRAC_W;

    logic         valid_in;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         valid_out;
    logic [W-1:0] product;
    logic [3:0]   flags;

    modport master (output valid_in, a, b, input valid_out, product, flags);
    modport slave  (input valid_in, a, b, output valid_out, product, flags);
endinterface

// File: rtl/float_multiplier_pipe.sv
// Pipelined IEEE-754 multiplier: input capture, unpack, significand multiply, normalise/round/pack.
// Subnormals flush to zero on input and output; flags = {invalid, overflow, underflow, inexact}.
module float_multiplier_pipe #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    float_multiplier_pipe_if.slave   bus
);
    localparam int W      = 1 + EXP_W + FRAC_W;
    localparam int SIG_W  = FRAC_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int XW     = EXP_W + 2;
    localparam int BIAS   = (1 << (EXP_W - 1)) - 1;

    localparam logic signed [XW-1:0] X_ONE  = XW'(1);
    localparam logic signed [XW-1:0] X_ZERO = '0;
    localparam logic signed [XW-1:0] X_EMAX = XW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]         QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    localparam logic [1:0] CLS_NUM  = 2'd0;
    localparam logic [1:0] CLS_ZERO = 2'd1;
    localparam logic [1:0] CLS_INF  = 2'd2;
    localparam logic [1:0] CLS_NAN  = 2'd3;

    // Stage 0: raw operand capture, so no input reaches the outputs combinationally
    logic         v0_q;
    logic [W-1:0] a0_q, b0_q;

    // Stage 1: unpacked fields
    logic                    v1_q, sign1_q;
    logic [SIG_W-1:0]        sig_a1_q, sig_b1_q, sig_a1_d, sig_b1_d;
    logic signed [XW-1:0]    exp1_q, exp1_d;
    logic [1:0]              cls1_q, cls1_d;

    // Stage 2: raw significand product
    logic                    v2_q, sign2_q;
    logic [PROD_W-1:0]       prod2_q;
    logic signed [XW-1:0]    exp2_q;
    logic [1:0]              cls2_q;

    // Stage 3: packed result
    logic                    v3_q;
    logic [W-1:0]            product_q, product_d;
    logic [3:0]              flags_q, flags_d;

    logic                    sa, sb;
    logic [EXP_W-1:0]        ea, eb;
    logic [FRAC_W-1:0]       fa, fb;
    logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign {sa, ea, fa} = a0_q;
    assign {sb, eb, fb} = b0_q;

    always_comb begin
        a_zero = ~|ea;
        b_zero = ~|eb;
        a_inf  = (&ea) & ~|fa;
        b_inf  = (&eb) & ~|fb;
        a_nan  = (&ea) & |fa;
        b_nan  = (&eb) & |fb;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
            cls1_d = CLS_NAN;
        else if (a_inf || b_inf)
            cls1_d = CLS_INF;
        else if (a_zero || b_zero)
            cls1_d = CLS_ZERO;
        else
            cls1_d = CLS_NUM;
        sig_a1_d = a_zero ? '0 : {1'b1, fa};
        sig_b1_d = b_zero ? '0 : {1'b1, fb};
        exp1_d   = {2'b00, ea} + {2'b00, eb} - XW'(BIAS);
    end

    logic [SIG_W-1:0]     mant;
    logic [SIG_W:0]       mant_r;
    logic                 grd, rnd, stk, inexact;
    logic signed [XW-1:0] exp_n, exp_r;

    always_comb begin
        mant  = prod2_q[PROD_W-2 -: SIG_W];
        grd   = prod2_q[PROD_W-2-SIG_W];
        rnd   = prod2_q[PROD_W-3-SIG_W];
        stk   = |prod2_q[PROD_W-4-SIG_W:0];
        exp_n = exp2_q;
        if (prod2_q[PROD_W-1]) begin
            mant  = prod2_q[PROD_W-1 -: SIG_W];
            grd   = prod2_q[PROD_W-1-SIG_W];
            rnd   = prod2_q[PROD_W-2-SIG_W];
            stk   = |prod2_q[PROD_W-3-SIG_W:0];
            exp_n = exp2_q + X_ONE;
        end
        inexact = grd | rnd | stk;
        // Round to nearest, ties to even
        mant_r  = {1'b0, mant} + {{SIG_W{1'b0}}, grd & (rnd | stk | mant[0])};
        exp_r   = exp_n;
        if (mant_r[SIG_W]) begin
            mant_r = mant_r >> 1;
            exp_r  = exp_n + X_ONE;
        end

        product_d = product_q;
        flags_d   = flags_q;
        case (cls2_q)
            CLS_NAN: begin
                product_d = QNAN;
                flags_d   = 4'b1000;
            end
            CLS_INF: begin
                product_d = {sign2_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                flags_d   = 4'b0000;
            end
            CLS_ZERO: begin
                product_d = {sign2_q, {(W-1){1'b0}}};
                flags_d   = 4'b0000;
            end
            default: begin
                if (exp_r >= X_EMAX) begin
                    product_d = {sign2_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    flags_d   = 4'b0101;
                end else if (exp_r <= X_ZERO) begin
                    product_d = {sign2_q, {(W-1){1'b0}}};
                    flags_d   = {2'b00, 1'b1, |mant_r};
                end else begin
                    product_d = {sign2_q, exp_r[EXP_W-1:0], mant_r[FRAC_W-1:0]};
                    flags_d   = {3'b000, inexact};
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q      <= 1'b0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            product_q <= '0;
            flags_q   <= '0;
        end else begin
            v0_q <= bus.valid_in;
            v1_q <= v0_q;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (v2_q) begin
                product_q <= product_d;
                flags_q   <= flags_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        a0_q     <= bus.a;
        b0_q     <= bus.b;
        sign1_q  <= sa ^ sb;
        sig_a1_q <= sig_a1_d;
        sig_b1_q <= sig_b1_d;
        exp1_q   <= exp1_d;
        cls1_q   <= cls1_d;
        sign2_q  <= sign1_q;
        prod2_q  <= sig_a1_q * sig_b1_q;
        exp2_q   <= exp1_q;
        cls2_q   <= cls1_q;
    end

    assign bus.valid_out = v3_q;
    assign bus.product   = product_q;
    assign bus.flags     = flags_q;
endmodule

// File: tb/tb_float_multiplier_pipe.sv
// Bench for float_multiplier_pipe: directed spec vectors plus randomized traffic against an
// integer-arithmetic reference model, with a cycle-level latency/valid scoreboard.
module tb_float_multiplier_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    float_multiplier_pipe_if bus ();
    float_multiplier_pipe dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit          v;
        logic [31:0] p;
        logic [3:0]  f;
        int          id;
    } exp_t;

    exp_t pipe[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_id  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, want);
        end
    endtask

    // Exact product rounded to 24 significant bits by remainder comparison.
    function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] p, output logic [3:0] f);
        int ea, eb, e, k, s;
        bit sg, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, inx;
        longint unsigned m, q, rem, half;
        sg = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            p = 32'h7FC00000; f = 4'b1000;
        end else if (a_inf || b_inf) begin
            p = {sg, 8'hFF, 23'd0}; f = 4'b0000;
        end else if (a_zero || b_zero) begin
            p = {sg, 31'd0}; f = 4'b0000;
        end else begin
            m = (64'h800000 | 64'(a[22:0])) * (64'h800000 | 64'(b[22:0]));
            k = 0;
            for (int i = 0; i < 64; i++) if (m[i]) k = i;
            s    = k - 23;
            q    = m >> s;
            rem  = m & ((64'd1 << s) - 64'd1);
            half = 64'd1 << (s - 1);
            inx  = (rem != 0);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                k = k + 1;
            end
            e = ea + eb - 127 + (k - 46);
            if (e >= 255) begin
                p = {sg, 8'hFF, 23'd0}; f = 4'b0101;
            end else if (e <= 0) begin
                p = {sg, 31'd0}; f = 4'b0011;
            end else begin
                p = {sg, e[7:0], q[22:0]}; f = {3'b000, inx};
            end
        end
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] x;
        int sel;
        x   = $urandom;
        sel = $urandom_range(0, 19);
        case (sel)
            0: x[30:23] = 8'h00;
            1: x[30:23] = 8'hFF;
            2: begin x[30:23] = 8'hFF; x[22:0] = 23'd0; end
            3: x[30:0] = 31'd0;
            4: x[30:23] = 8'($urandom_range(1, 20));
            5: x[30:23] = 8'($urandom_range(230, 254));
            default: x[30:23] = 8'($urandom_range(100, 154));
        endcase
        return x;
    endfunction

    // One clock: drive at negedge, record what the edge sampled, check outputs at next negedge.
    task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [3:0] f);
        exp_t e;
        bus.valid_in = v;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        if (rst) pipe.delete();
        else begin
            pipe.push_back('{v, p, f, n_id});
            if (v) n_id++;
        end
        @(negedge clk);
        if (pipe.size() == 4) begin
            e = pipe.pop_front();
            check("valid_out", 32'(bus.valid_out), 32'(e.v));
            if (e.v) begin
                check($sformatf("product[%0d]", e.id), bus.product, e.p);
                check($sformatf("flags[%0d]", e.id), 32'(bus.flags), 32'(e.f));
            end
        end else begin
            check("valid_out_idle", 32'(bus.valid_out), 32'd0);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] p;
        logic [3:0]  f;
        ref_mul(a, b, p, f);
        drive(1'b1, a, b, p, f);
    endtask

    task automatic idle();
        drive(1'b0, $urandom, $urandom, 32'd0, 4'd0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.valid_in = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        idle();
        drive(1'b1, 32'h3F800000, 32'h3F800000, 32'd0, 4'd0);
        check("reset_product", bus.product, 32'd0);
        check("reset_flags", 32'(bus.flags), 32'd0);
        rst = 1'b0;

        // Directed vectors with spec-given results
        drive(1'b1, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
        idle();
        drive(1'b1, 32'h3F99999A, 32'h3F8CCCCD, 32'h3FA8F5C3, 4'b0001);
        drive(1'b1, 32'hC0000000, 32'h3F000000, 32'hBF800000, 4'b0000);
        drive(1'b1, 32'h00000000, 32'hC0400000, 32'h80000000, 4'b0000);
        drive(1'b1, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
        drive(1'b1, 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101);
        drive(1'b1, 32'h00800000, 32'h00800000, 32'h00000000, 4'b0011);
        repeat (4) idle();

        // Throughput: 8 back-to-back, one-cycle gap, 2 more
        repeat (8) issue(rnd_op(), rnd_op());
        idle();
        repeat (2) issue(rnd_op(), rnd_op());
        repeat (4) idle();

        // Reset while three pairs are in flight; the pair present during reset is dropped
        repeat (3) issue(rnd_op(), rnd_op());
        rst = 1'b1;
        drive(1'b1, 32'h40000000, 32'h40000000, 32'd0, 4'd0);
        rst = 1'b0;
        repeat (3) idle();
        drive(1'b1, 32'h40400000, 32'hBF000000, 32'hBFC00000, 4'b0000);
        repeat (4) idle();

        // Random traffic with random bubbles
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) issue(rnd_op(), rnd_op());
            else idle();
        end
        repeat (4) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
